// File: rtl/irrigation_countdown_timer_pkg.sv
// Shared types and constants for the irrigation countdown timer.
// Optional feature macro: TIMER_EXTEND_EN (one-minute extend).
package irrigation_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // BCD MM:SS, packed in display order so 16'hMMSS maps directly.
    typedef struct packed {
        logic [3:0] min_d;
        logic [3:0] min_u;
        logic [3:0] sec_d;
        logic [3:0] sec_u;
    } bcd_time_t;

    localparam logic [15:0] SPRINKLER_PRESET = 16'h1500;
    localparam logic [15:0] DRIPPER_PRESET   = 16'h3000;
    localparam logic [15:0] MAX_TIME         = 16'h9959;

    function automatic logic is_zero(input bcd_time_t t);
        return t == '0;
    endfunction

endpackage

// File: rtl/irrigation_countdown_timer_if.sv
// Controller-side bundle of the irrigation timer: control strobes in,
// display digits and status out. master = controller, slave = timer.
interface irrigation_countdown_timer_if #(
    parameter int MODE_W = 1
);
    logic              tick_1hz;
    logic              start;
    logic              abort;
    logic              hold;
    logic [MODE_W-1:0] mode;
    logic              extend;
    logic [3:0]        minutes_d;
    logic [3:0]        minutes_u;
    logic [3:0]        seconds_d;
    logic [3:0]        seconds_u;
    logic              valve_on;
    logic              done;

    modport master (
        output tick_1hz, start, abort, hold, mode, extend,
        input  minutes_d, minutes_u, seconds_d, seconds_u, valve_on, done
    );

    modport slave (
        input  tick_1hz, start, abort, hold, mode, extend,
        output minutes_d, minutes_u, seconds_d, seconds_u, valve_on, done
    );
endinterface

// File: rtl/irrigation_countdown_timer_bcd_time_step.sv
// Combinational BCD time step: optional +1 minute (saturating at 99:59)
// followed by an optional one-second decrement. Extend logic only exists
// when TIMER_EXTEND_EN is defined.
module bcd_time_step
    import irrigation_timer_pkg::*;
(
    input  bcd_time_t t_in,
    input  logic      inc,
    input  logic      dec,
    output bcd_time_t t_out
);

    // One-second decrement with BCD borrow; caller never passes 00:00.
    function automatic bcd_time_t dec_time(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (r.sec_u != 4'd0) begin
            r.sec_u = r.sec_u - 4'd1;
        end else begin
            r.sec_u = 4'd9;
            if (r.sec_d != 4'd0) begin
                r.sec_d = r.sec_d - 4'd1;
            end else begin
                r.sec_d = 4'd5;
                if (r.min_u != 4'd0) begin
                    r.min_u = r.min_u - 4'd1;
                end else begin
                    r.min_u = 4'd9;
                    r.min_d = r.min_d - 4'd1;
                end
            end
        end
        return r;
    endfunction

    bcd_time_t grown;

`ifdef TIMER_EXTEND_EN
    // Add one minute; 99:xx clamps to the display maximum.
    function automatic bcd_time_t inc_time(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.min_d == 4'd9 && t.min_u == 4'd9) begin
            r = bcd_time_t'(MAX_TIME);
        end else if (t.min_u == 4'd9) begin
            r.min_u = 4'd0;
            r.min_d = t.min_d + 4'd1;
        end else begin
            r.min_u = t.min_u + 4'd1;
        end
        return r;
    endfunction

    assign grown = inc ? inc_time(t_in) : t_in;
`else
    logic unused_inc;
    assign unused_inc = inc;
    assign grown      = t_in;
`endif

    assign t_out = dec ? dec_time(grown) : grown;

endmodule

// File: rtl/irrigation_countdown_timer.sv
// Irrigation countdown timer: loads a BCD MM:SS preset per mode on start,
// counts down on the 1 Hz tick, drives valve and display digits.
// Optional feature macro: TIMER_EXTEND_EN (extend adds one minute).
module irrigation_countdown_timer
    import irrigation_timer_pkg::*;
#(
    parameter int                    NUM_MODES = 2,
    parameter int                    MODE_W    = 1,
    parameter logic [NUM_MODES*16-1:0] PRESETS = {DRIPPER_PRESET, SPRINKLER_PRESET}
) (
    input  logic                        clk,
    input  logic                        reset,
    irrigation_countdown_timer_if.slave bus
);

    state_t            state_q, state_d;
    bcd_time_t         time_q, time_d;
    bcd_time_t         preset_sel;
    bcd_time_t         stepped;
    logic              valve_q, valve_d;
    logic              done_q, done_d;
    logic [MODE_W-1:0] mode_sel;
    logic              mode_ok;
    logic              do_dec;
    logic              do_inc;

    assign mode_sel = bus.mode;
    assign mode_ok  = ({{(32-MODE_W){1'b0}}, mode_sel} < 32'(NUM_MODES));

    // Preset lookup for the requested mode; out-of-range modes never load.
    always_comb begin
        preset_sel = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (mode_sel == MODE_W'(i)) preset_sel = bcd_time_t'(PRESETS[i*16 +: 16]);
        end
    end

    // Ticks only count while actually running; hold drops them.
    assign do_dec = (state_q == RUN) && !bus.hold && bus.tick_1hz;
    assign do_inc = bus.extend;

    bcd_time_step u_step (
        .t_in  (time_q),
        .inc   (do_inc),
        .dec   (do_dec),
        .t_out (stepped)
    );

    // Next state and time: abort > start > extend > tick.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        if (bus.abort) begin
            state_d = IDLE;
            time_d  = '0;
        end else if (bus.start && mode_ok) begin
            state_d = RUN;
            time_d  = preset_sel;
        end else if (state_q == RUN || state_q == PAUSE) begin
            if (is_zero(time_q)) begin
                // A 00:00 preset finishes on the cycle after loading.
                state_d = DONE;
            end else begin
                time_d = stepped;
                if (is_zero(stepped)) state_d = DONE;
                else                  state_d = bus.hold ? PAUSE : RUN;
            end
        end
        valve_d = (state_d == RUN) || (state_d == PAUSE);
        done_d  = (state_d == DONE);
    end

    // State, time and status flags, all registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            time_q  <= '0;
            valve_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            valve_q <= valve_d;
            done_q  <= done_d;
        end
    end

    assign bus.minutes_d = time_q.min_d;
    assign bus.minutes_u = time_q.min_u;
    assign bus.seconds_d = time_q.sec_d;
    assign bus.seconds_u = time_q.sec_u;
    assign bus.valve_on  = valve_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_irrigation_countdown_timer.sv
// Bench for irrigation_countdown_timer: two instances (default presets and
// a 3-mode override with 01:30 / 00:02 / 00:00) driven in lockstep against
// a seconds-based reference model, directed cases then random traffic.
module tb_irrigation_countdown_timer;
    import irrigation_timer_pkg::*;

`ifdef TIMER_EXTEND_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    irrigation_countdown_timer_if #(.MODE_W(1)) if0 ();
    irrigation_countdown_timer_if #(.MODE_W(2)) if1 ();

    irrigation_countdown_timer dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    irrigation_countdown_timer #(
        .NUM_MODES (3),
        .MODE_W    (2),
        .PRESETS   ({16'h0000, 16'h0002, 16'h0130})
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int m_st [2];
    int m_s  [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Preset durations in plain seconds.
    function automatic int preset_s(input int d, input int md);
        if (d == 0) return (md == 0) ? 900 : 1800;
        case (md)
            0:       return 90;
            1:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [15:0] to_digits(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [15:0] dut_time(input int d);
        if (d == 0) return {if0.minutes_d, if0.minutes_u, if0.seconds_d, if0.seconds_u};
        return {if1.minutes_d, if1.minutes_u, if1.seconds_d, if1.seconds_u};
    endfunction

    task automatic model_step(input int d, input bit tk, input bit st, input bit ab,
                              input bit hd, input int md, input bit ex);
        int n;
        n = (d == 0) ? 2 : 3;
        if (ab) begin
            m_st[d] = M_IDLE;
            m_s[d]  = 0;
        end else if (st && md < n) begin
            m_st[d] = M_RUN;
            m_s[d]  = preset_s(d, md);
        end else if (m_st[d] == M_RUN || m_st[d] == M_PAUSE) begin
            if (m_s[d] == 0) begin
                m_st[d] = M_DONE;
            end else begin
                if (EXT_EN && ex) m_s[d] = (m_s[d] + 60 > 5999) ? 5999 : m_s[d] + 60;
                if (m_st[d] == M_RUN && !hd && tk) m_s[d] = m_s[d] - 1;
                if (m_s[d] == 0) m_st[d] = M_DONE;
                else             m_st[d] = hd ? M_PAUSE : M_RUN;
            end
        end
    endtask

    task automatic check_all();
        chk("d0_time",  dut_time(0), to_digits(m_s[0]));
        chk("d0_valve", if0.valve_on, (m_st[0] == M_RUN || m_st[0] == M_PAUSE));
        chk("d0_done",  if0.done,     (m_st[0] == M_DONE));
        chk("d1_time",  dut_time(1), to_digits(m_s[1]));
        chk("d1_valve", if1.valve_on, (m_st[1] == M_RUN || m_st[1] == M_PAUSE));
        chk("d1_done",  if1.done,     (m_st[1] == M_DONE));
    endtask

    task automatic drive(input bit tk, input bit st, input bit ab, input bit hd,
                         input logic [1:0] md, input bit ex);
        if0.tick_1hz = tk; if0.start = st; if0.abort = ab;
        if0.hold = hd; if0.mode = md[0]; if0.extend = ex;
        if1.tick_1hz = tk; if1.start = st; if1.abort = ab;
        if1.hold = hd; if1.mode = md; if1.extend = ex;
    endtask

    // One clock: drive at negedge, advance model, check just after posedge.
    task automatic step(input bit tk, input bit st, input bit ab, input bit hd,
                        input logic [1:0] md, input bit ex);
        @(negedge clk);
        drive(tk, st, ab, hd, md, ex);
        model_step(0, tk, st, ab, hd, int'(md[0]), ex);
        model_step(1, tk, st, ab, hd, int'(md), ex);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        bit hold_lvl;
        drive(0, 0, 0, 0, 2'd0, 0);
        for (int d = 0; d < 2; d++) begin
            m_st[d] = M_IDLE;
            m_s[d]  = 0;
        end
        #12;
        chk("reset_time0", dut_time(0), 16'h0000);
        chk("reset_valve0", if0.valve_on, 1'b0);
        chk("reset_done1", if1.done, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Start mode 0 then three ticks.
        step(0, 1, 0, 0, 2'd0, 0);
        chk("start_1500", dut_time(0), 16'h1500);
        chk("start_valve", if0.valve_on, 1'b1);
        step(1, 0, 0, 0, 2'd0, 0); chk("tick_1459", dut_time(0), 16'h1459);
        step(1, 0, 0, 0, 2'd0, 0); chk("tick_1458", dut_time(0), 16'h1458);
        step(1, 0, 0, 0, 2'd0, 0); chk("tick_1457", dut_time(0), 16'h1457);

        // Recount to mode 1 with a simultaneous tick, then hold.
        step(1, 1, 0, 0, 2'd1, 0);
        chk("start_tick_3000", dut_time(0), 16'h3000);
        chk("load_0002", dut_time(1), 16'h0002);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 1, 2'd1, 0);
            chk("hold_3000", dut_time(0), 16'h3000);
            chk("hold_valve", if0.valve_on, 1'b1);
        end
        step(0, 0, 0, 0, 2'd1, 0);
        step(1, 0, 0, 0, 2'd1, 0);
        chk("release_2959", dut_time(0), 16'h2959);
        chk("short_0001", dut_time(1), 16'h0001);
        step(1, 0, 0, 0, 2'd1, 0);
        chk("short_0000", dut_time(1), 16'h0000);
        chk("short_done", if1.done, 1'b1);
        chk("short_valve", if1.valve_on, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 2'd0, 0);
            chk("done_held", if1.done, 1'b1);
        end
        step(0, 0, 1, 0, 2'd0, 0);
        chk("abort_done", if1.done, 1'b0);
        chk("abort_time", dut_time(0), 16'h0000);

        // 00:00 preset: RUN for one cycle, then DONE without a tick.
        step(0, 1, 0, 0, 2'd2, 0);
        chk("zero_valve", if1.valve_on, 1'b1);
        step(0, 0, 0, 0, 2'd2, 0);
        chk("zero_done", if1.done, 1'b1);
        chk("zero_valve_off", if1.valve_on, 1'b0);

        // Invalid mode ignored; abort wins over start.
        step(0, 0, 1, 0, 2'd0, 0);
        step(0, 1, 0, 0, 2'd3, 0);
        chk("bad_mode_valve", if1.valve_on, 1'b0);
        chk("bad_mode_time", dut_time(1), 16'h0000);
        step(0, 1, 1, 0, 2'd1, 0);
        chk("abort_start_valve", if0.valve_on, 1'b0);
        chk("abort_start_time", dut_time(0), 16'h0000);

        // Extend: 14:10 + 85 min -> 99:10, then saturate.
        step(0, 1, 0, 0, 2'd0, 0);
        for (int i = 0; i < 50; i++) step(1, 0, 0, 0, 2'd0, 0);
        chk("pre_ext_1410", dut_time(0), 16'h1410);
        for (int i = 0; i < 85; i++) step(0, 0, 0, 0, 2'd0, 1);
        chk("ext_9910", dut_time(0), EXT_EN ? 16'h9910 : 16'h1410);
        step(0, 0, 0, 0, 2'd0, 1);
        chk("ext_sat_9959", dut_time(0), EXT_EN ? 16'h9959 : 16'h1410);
        step(0, 0, 1, 0, 2'd0, 0);
        step(0, 1, 0, 0, 2'd0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 2'd0, 1);
        chk("ext_0530", dut_time(1), EXT_EN ? 16'h0530 : 16'h0130);
        step(1, 0, 0, 0, 2'd0, 1);
        chk("ext_tick_0629", dut_time(1), EXT_EN ? 16'h0629 : 16'h0129);

        // Async reset mid-run at 12:34.
        step(0, 1, 0, 0, 2'd0, 0);
        for (int i = 0; i < 146; i++) step(1, 0, 0, 0, 2'd0, 0);
        chk("pre_rst_1234", dut_time(0), 16'h1234);
        @(negedge clk);
        drive(1, 0, 0, 0, 2'd0, 0);
        reset = 1'b1;
        #1;
        chk("async_rst_time", dut_time(0), 16'h0000);
        chk("async_rst_valve", if0.valve_on, 1'b0);
        for (int d = 0; d < 2; d++) begin
            m_st[d] = M_IDLE;
            m_s[d]  = 0;
        end
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        drive(0, 0, 0, 0, 2'd0, 0);
        reset = 1'b0;
        step(1, 0, 0, 0, 2'd0, 0);
        chk("post_rst_time", dut_time(0), 16'h0000);

        // Random traffic against the model.
        hold_lvl = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) hold_lvl = ~hold_lvl;
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 40) == 0),
                 ($urandom_range(0, 150) == 0),
                 hold_lvl,
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 12) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
